uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and frame sequencer that shares one UART transmitter among several byte requesters. It grants one requester at a time and drives the transmitter's parallel data and level-sensitive write strobe for a fixed frame time. It enforces an idle guard gap before the next grant. It sits between on-chip producers (APB-side buffers, debug ports) and the single UART_Tx instance.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, data width per byte
- FRAME_CYCLES, 10, clk cycles uart_wr stays high per byte (≥1)
- GAP_CYCLES, 2, clk cycles uart_wr stays low after each frame (≥1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- req  input  NREQ  per-requester request, level
- req_data  input  NREQ*DW  requester i byte at bits [i*DW +: DW]
- gnt  output  NREQ  one-hot, single-cycle acceptance pulse
- grant_id  output  $clog2(NREQ)  index of current/last winner
- uart_data  output  DW  byte to transmitter, registered
- uart_wr  output  1  transmitter write strobe, level for whole frame
- busy  output  1  high in XMIT and GAP

## Operation
- FSM states: IDLE, XMIT, GAP.
- IDLE: if any req bit is high, the winner is the first set bit searching from pointer ptr upward with wrap. On the next edge:
  - req_data[winner] is latched into uart_data.
  - gnt[winner] pulses.
  - grant_id becomes the winner.
  - ptr becomes winner+1 mod NREQ.
  - The FSM moves to XMIT.
- XMIT: uart_wr=1, and the counter runs FRAME_CYCLES cycles. On the last count the FSM moves to GAP.
- GAP: uart_wr=0, and the counter runs GAP_CYCLES cycles. The FSM then moves to IDLE. req is ignored in XMIT and GAP.
- uart_data holds its value through XMIT and GAP. It changes only on a new grant.
- Requester rules:
  - Keep req high and req_data stable until gnt is seen.
  - Dropping req before gnt withdraws the request. This is legal, and no grant is given.
  - After gnt, the requester may hold req high with the next byte. It competes again in the next IDLE.
- Counter width is $clog2(max(FRAME_CYCLES,GAP_CYCLES)+1). It reloads to 0 on every state entry.
- Invalid state encoding recovers to IDLE.

## Timing
- Reset values: state=IDLE, ptr=0, gnt=0, grant_id=0, uart_data=0, uart_wr=0, busy=0, counter=0.
- Reset asserted mid-frame: all outputs go to reset values immediately, asynchronously. The pending byte is lost.
- Latency: req sampled high in IDLE at edge N gives gnt, uart_wr, busy and the new uart_data all high/valid from edge N+1.
- gnt is high for exactly cycle N+1.
- uart_wr is high for cycles N+1 .. N+FRAME_CYCLES.
- busy is high for cycles N+1 .. N+FRAME_CYCLES+GAP_CYCLES.
- Earliest next grant: edge N+FRAME_CYCLES+GAP_CYCLES+1. The grant period is FRAME_CYCLES+GAP_CYCLES+1 cycles.
- Simultaneous requests: exactly one is granted. Under continuous all-high req, grant order is strict rotation from ptr.
- Single active requester: it is granted every period regardless of ptr.
- NREQ not a power of two: the ptr wrap is explicit, with no out-of-range index.

## Configuration
- UART_ARB_PRIO0_EN defined:
  - Requester 0 wins whenever its req is high in IDLE, overriding rotation.
  - ptr is not updated on a priority win.
  - Other requesters rotate normally when req[0] is low.
- Undefined: pure round-robin, with requester 0 treated like all others.

## Structure
- Package uart_arb_pkg holds:
  - the state enum (IDLE, XMIT, GAP);
  - width helper constants for ptr/grant_id and the counter;
  - default parameter constants.
- One combinational sub-module, uart_rr_pick:
  - Inputs: req vector, ptr.
  - Outputs: winner index, any_req.
  - The UART_ARB_PRIO0_EN override lives in the top, not in the picker.

## Test plan
- Single byte: req[1]=1 with data 8'hA5, at defaults.
  - gnt[1] pulses one cycle after sampling, and uart_data=8'hA5.
  - uart_wr is high 10 cycles then low 2, busy is high 12, then FSM returns to IDLE.
- Contention: req=4'b1111 held, bytes 8'h10..8'h13.
  - Grants occur in order 0,1,2,3,0, each 13 cycles apart.
  - uart_data matches each grant.
- Withdrawal: req[2] pulsed high then dropped while busy on requester 0's frame.
  - No gnt[2] occurs, and the next IDLE stays idle.
- Reset mid-frame: rst driven low at cycle 5 of XMIT.
  - uart_wr, busy and uart_data go to 0 at once.
  - After release, req[3] is granted first with ptr=0 rotation rules.
- Priority build (UART_ARB_PRIO0_EN): req=4'b0101 held.
  - Requester 0 is granted every period, and requester 2 never.
  - After req[0] drops, requester 2 is granted.
- Odd NREQ=3: req=3'b111 held.
  - Grants rotate 0,1,2,0 with no illegal grant_id.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and width helpers for the UART transmit arbiter.
// Contents: state enum, default parameter values, index/counter width helpers.
package uart_arb_pkg;

  localparam int unsigned NREQ_DEF         = 4;
  localparam int unsigned DW_DEF           = 8;
  localparam int unsigned FRAME_CYCLES_DEF = 10;
  localparam int unsigned GAP_CYCLES_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XMIT = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  // Width of a requester index (ptr, grant_id, winner).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the frame/gap counter.
  function automatic int unsigned cnt_w(input int unsigned frame, input int unsigned gap);
    return $clog2(((frame > gap) ? frame : gap) + 1);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, with wrap.
// Ports: req (request vector), ptr (search start), winner (index), any_req.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]          req,
  input  logic [idx_w(NREQ)-1:0]   ptr,
  output logic [idx_w(NREQ)-1:0]   winner,
  output logic                     any_req
);

  localparam int unsigned IW = idx_w(NREQ);

  int unsigned     idx;
  logic [IW-1:0]   pos;

  // Explicit wrap keeps the index in range when NREQ is not a power of two.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    pos     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      pos = IW'(idx);
      if (!any_req && req[pos]) begin
        any_req = 1'b1;
        winner  = pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and frame sequencer sharing one UART transmitter.
// Ports: clk, rst (async active-low), req/req_data (requesters),
//        gnt (one-cycle accept pulse), grant_id, uart_data, uart_wr, busy.
// Build option: UART_ARB_PRIO0_EN gives requester 0 absolute priority.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ         = NREQ_DEF,
  parameter int unsigned DW           = DW_DEF,
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES   = GAP_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         gnt,
  output logic [idx_w(NREQ)-1:0]  grant_id,
  output logic [DW-1:0]           uart_data,
  output logic                    uart_wr,
  output logic                    busy
);

  localparam int unsigned IW = idx_w(NREQ);
  localparam int unsigned CW = cnt_w(FRAME_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NREQ - 1);

  arb_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_d;
  logic [IW-1:0]   grant_id_d;
  logic [DW-1:0]   uart_data_d;
  logic            uart_wr_d;
  logic            busy_d;

  logic [IW-1:0]   rr_winner;
  logic [IW-1:0]   winner;
  logic            any_req;
  logic            prio_win;

  uart_rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (rr_winner),
    .any_req (any_req)
  );

  // Priority override sits outside the picker so the picker stays pure round-robin.
`ifdef UART_ARB_PRIO0_EN
  assign prio_win = req[0];
`else
  assign prio_win = 1'b0;
`endif
  assign winner = prio_win ? '0 : rr_winner;

  // Next-state and next-output logic; every register has a next value here.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    grant_id_d  = grant_id;
    uart_data_d = uart_data;
    uart_wr_d   = uart_wr;
    busy_d      = busy;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = XMIT;
          cnt_d       = '0;
          gnt_d       = NREQ'(1) << winner;
          grant_id_d  = winner;
          uart_data_d = req_data[32'(winner)*DW +: DW];
          uart_wr_d   = 1'b1;
          busy_d      = 1'b1;
          // A priority win leaves the rotation where it was.
          if (!prio_win) ptr_d = (winner == LAST_IDX) ? '0 : winner + IW'(1);
        end
      end
      XMIT: begin
        if (cnt_q == FRAME_LAST) begin
          state_d   = GAP;
          cnt_d     = '0;
          uart_wr_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        uart_wr_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      gnt       <= '0;
      grant_id  <= '0;
      uart_data <= '0;
      uart_wr   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      gnt       <= gnt_d;
      grant_id  <= grant_id_d;
      uart_data <= uart_data_d;
      uart_wr   <= uart_wr_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a 4-requester instance at default
// timing and a 3-requester instance with short frames, both checked every
// cycle against a time-since-grant reference model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NA = 4, FA = 10, GA = 2;
  localparam int NB = 3, FB = 3,  GB = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] rq [2];
  logic [7:0] dv [2][8];

  logic [3:0] gnt_a; logic [1:0] gid_a; logic [7:0] ud_a; logic wr_a, busy_a;
  logic [2:0] gnt_b; logic [1:0] gid_b; logic [7:0] ud_b; logic wr_b, busy_b;

  uart_tx_arbiter #(.NREQ(NA), .DW(8), .FRAME_CYCLES(FA), .GAP_CYCLES(GA)) u_dut_a (
    .clk(clk), .rst(rst), .req(rq[0][3:0]),
    .req_data({dv[0][3], dv[0][2], dv[0][1], dv[0][0]}),
    .gnt(gnt_a), .grant_id(gid_a), .uart_data(ud_a), .uart_wr(wr_a), .busy(busy_a));

  uart_tx_arbiter #(.NREQ(NB), .DW(8), .FRAME_CYCLES(FB), .GAP_CYCLES(GB)) u_dut_b (
    .clk(clk), .rst(rst), .req(rq[1][2:0]),
    .req_data({dv[1][2], dv[1][1], dv[1][0]}),
    .gnt(gnt_b), .grant_id(gid_b), .uart_data(ud_b), .uart_wr(wr_b), .busy(busy_b));

  // Reference model: m_t = cycles since the grant edge (0 = idle).
  int         m_t [2];
  int         m_ptr [2];
  int         m_id [2];
  logic [7:0] m_data [2];
  int         pol [2];   // requester policy: 0 drop after grant, 1 hold, 2 random

  int n_eval = 0, n_fail = 0;
  int cyc = 0;
  int la_id[$], la_cyc[$], lb_id[$];
  logic [7:0] la_data[$];
  int wr_cnt_a, busy_cnt_a, g2_cnt;
  int exp_ord[5];

  function automatic int nr(input int u);  return (u == 0) ? NA : NB; endfunction
  function automatic int fr(input int u);  return (u == 0) ? FA : FB; endfunction
  function automatic int gp(input int u);  return (u == 0) ? GA : GB; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_t[u] = 0; m_ptr[u] = 0; m_id[u] = 0; m_data[u] = 8'h00;
    end
  endtask

  task automatic model_edge(input int u);
    int   n, w;
    bit   pri;
    logic [2:0] ix;
    n = nr(u); w = -1; pri = 1'b0;
    if (m_t[u] == 0) begin
`ifdef UART_ARB_PRIO0_EN
      pri = rq[u][0];
`endif
      if (pri) w = 0;
      else
        for (int k = 0; k < n; k++) begin
          ix = 3'((m_ptr[u] + k) % n);
          if (w < 0 && rq[u][ix]) w = int'(ix);
        end
      if (w >= 0) begin
        m_t[u] = 1; m_id[u] = w; m_data[u] = dv[u][w];
        if (!pri) m_ptr[u] = (w + 1) % n;
      end
    end else begin
      m_t[u] = (m_t[u] == fr(u) + gp(u)) ? 0 : m_t[u] + 1;
    end
  endtask

  task automatic check_all();
    logic [7:0] g_o, d_o;
    logic [1:0] i_o;
    logic       w_o, b_o;
    for (int u = 0; u < 2; u++) begin
      if (u == 0) begin g_o = 8'(gnt_a); i_o = gid_a; d_o = ud_a; w_o = wr_a; b_o = busy_a; end
      else        begin g_o = 8'(gnt_b); i_o = gid_b; d_o = ud_b; w_o = wr_b; b_o = busy_b; end
      chk($sformatf("gnt[%0d]", u), 32'(g_o), (m_t[u] == 1) ? (32'(1) << m_id[u]) : 32'(0));
      chk($sformatf("uart_wr[%0d]", u), 32'(w_o), 32'(m_t[u] >= 1 && m_t[u] <= fr(u)));
      chk($sformatf("busy[%0d]", u), 32'(b_o), 32'(m_t[u] != 0));
      chk($sformatf("grant_id[%0d]", u), 32'(i_o), 32'(m_id[u]));
      chk($sformatf("uart_data[%0d]", u), 32'(d_o), 32'(m_data[u]));
    end
  endtask

  task automatic track();
    cyc++;
    if (gnt_a != 4'd0) begin
      la_id.push_back(int'(gid_a)); la_cyc.push_back(cyc); la_data.push_back(ud_a);
    end
    if (gnt_b != 3'd0) lb_id.push_back(int'(gid_b));
    wr_cnt_a   += int'(wr_a);
    busy_cnt_a += int'(busy_a);
    if (gnt_a[2]) g2_cnt++;
  endtask

  task automatic clear_logs();
    la_id.delete(); la_cyc.delete(); la_data.delete(); lb_id.delete();
    wr_cnt_a = 0; busy_cnt_a = 0; g2_cnt = 0;
  endtask

  // Requesters react to the grant they were just given (as per the model).
  task automatic drive_reqs();
    bit granted;
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < nr(u); i++) begin
        granted = (m_t[u] == 1 && m_id[u] == i);
        case (pol[u])
          0: if (granted) rq[u][i] = 1'b0;
          2: begin
            if (granted) begin
              if ($urandom_range(1) == 1) dv[u][i] = 8'($urandom);
              else rq[u][i] = 1'b0;
            end else if (rq[u][i]) begin
              if ($urandom_range(15) == 0) rq[u][i] = 1'b0;
            end else if ($urandom_range(3) == 0) begin
              rq[u][i] = 1'b1; dv[u][i] = 8'($urandom);
            end
          end
          default: ;
        endcase
      end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      model_edge(0); model_edge(1);
      @(negedge clk);
      check_all();
      track();
      drive_reqs();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    rq[0] = 8'h00; rq[1] = 8'h00;
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    rq[0] = 8'h00; rq[1] = 8'h00;
    for (int u = 0; u < 2; u++) for (int i = 0; i < 8; i++) dv[u][i] = 8'h00;
    pol[0] = 0; pol[1] = 0;
    model_reset();
    clear_logs();
    do_reset();

    // Single byte from requester 1.
    clear_logs();
    dv[0][1] = 8'hA5; rq[0][1] = 1'b1;
    step(16);
    chk("single_grants", 32'(la_id.size()), 32'd1);
    if (la_id.size() > 0) chk("single_id", 32'(la_id[0]), 32'd1);
    chk("single_wr_cycles", 32'(wr_cnt_a), 32'd10);
    chk("single_busy_cycles", 32'(busy_cnt_a), 32'd12);
    chk("single_data_hold", 32'(ud_a), 32'hA5);

    // Contention: all four held high.
    do_reset();
    clear_logs();
    pol[0] = 1;
    for (int i = 0; i < 4; i++) dv[0][i] = 8'(8'h10 + i);
    rq[0] = 8'h0F;
    step(65);
    exp_ord = '{0, 1, 2, 3, 0};
    chk("cont_grants", 32'(la_id.size()), 32'd5);
    for (int i = 0; i < 5 && i < la_id.size(); i++) begin
      chk($sformatf("cont_id%0d", i), 32'(la_id[i]), 32'(exp_ord[i]));
      chk($sformatf("cont_data%0d", i), 32'(la_data[i]), 32'(8'h10 + exp_ord[i]));
      if (i > 0) chk($sformatf("cont_period%0d", i), 32'(la_cyc[i] - la_cyc[i-1]), 32'd13);
    end

    // Withdrawal: requester 2 drops its request while requester 0 transmits.
    do_reset();
    clear_logs();
    pol[0] = 0;
    dv[0][0] = 8'h3C; rq[0][0] = 1'b1;
    step(3);
    dv[0][2] = 8'h77; rq[0][2] = 1'b1;
    step(4);
    rq[0][2] = 1'b0;
    step(20);
    chk("withdraw_gnt2", 32'(g2_cnt), 32'd0);
    chk("withdraw_grants", 32'(la_id.size()), 32'd1);
    chk("withdraw_idle", 32'(busy_a), 32'd0);

    // Reset asserted mid-frame.
    do_reset();
    clear_logs();
    dv[0][1] = 8'h5A; rq[0][1] = 1'b1;
    step(5);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("rst_uart_wr", 32'(wr_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_uart_data", 32'(ud_a), 32'd0);
    chk("rst_gnt", 32'(gnt_a), 32'd0);
    chk("rst_grant_id", 32'(gid_a), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    clear_logs();
    rq[0] = 8'h00;
    dv[0][3] = 8'hC3; rq[0][3] = 1'b1;
    step(3);
    chk("rst_next_grants", 32'(la_id.size()), 32'd1);
    if (la_id.size() > 0) chk("rst_next_id", 32'(la_id[0]), 32'd3);
    step(12);

    // Requesters 0 and 2 held; then 0 drops.
    do_reset();
    clear_logs();
    pol[0] = 1;
    dv[0][0] = 8'h40; dv[0][2] = 8'h42;
    rq[0] = 8'h05;
    step(52);
`ifdef UART_ARB_PRIO0_EN
    exp_ord = '{0, 0, 0, 0, 2};
`else
    exp_ord = '{0, 2, 0, 2, 2};
`endif
    rq[0][0] = 1'b0;
    step(13);
    chk("prio_grants", 32'(la_id.size()), 32'd5);
    for (int i = 0; i < 5 && i < la_id.size(); i++)
      chk($sformatf("prio_id%0d", i), 32'(la_id[i]), 32'(exp_ord[i]));

    // Three requesters, all held, short frames.
    do_reset();
    clear_logs();
    pol[0] = 0; pol[1] = 1;
    for (int i = 0; i < 3; i++) dv[1][i] = 8'(8'hB0 + i);
    rq[1] = 8'h07;
    step(20);
    exp_ord = '{0, 1, 2, 0, 0};
    chk("odd_grants", 32'(lb_id.size()), 32'd4);
    for (int i = 0; i < 4 && i < lb_id.size(); i++)
      chk($sformatf("odd_id%0d", i), 32'(lb_id[i]), 32'(exp_ord[i]));

    // Random traffic on both instances.
    do_reset();
    clear_logs();
    pol[0] = 2; pol[1] = 2;
    step(3000);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
